// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen -- RGB parallel-LCD timing and test-pattern generator.
//
// Divides clk by CLK_DIV to form dclk. It runs a free-running (h,v) raster over
// H_TOT x V_TOT and registers all panel outputs together from the same (h,v).
// This keeps de, syncs, rgb, x and y exactly aligned. Outputs change on the clk
// edge where dclk falls, so the panel samples them on the next dclk rise.
//
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   mode[1:0]           0 bars, 1 gradient, 2 checkerboard, 3 solid fill
//                       (latched at the start of each frame)
//   fill_rgb            solid-fill colour {R,G,B}, sampled on every pixel
//   red/green/blue      pixel data, forced to 0 outside the active area
//   dclk, de, hsync, vsync  panel timing pins
//   x[10:0], y[9:0]     position of the pixel currently on the outputs
//   frame_start         1-clk pulse while the outputs show (0,0)
//   frame_cnt[15:0]     (LCD_FRAME_CNT_EN only) frame counter. It animates the
//                       gradient pattern.
//
// Optional feature macro: LCD_FRAME_CNT_EN.
module lcd_timing_gen #(
  parameter int       CLK_DIV   = 2,
  parameter int       H_ACTIVE  = 480,
  parameter int       H_FP      = 8,
  parameter int       H_SYNC    = 4,
  parameter int       H_BP      = 43,
  parameter int       V_ACTIVE  = 272,
  parameter int       V_FP      = 8,
  parameter int       V_SYNC    = 4,
  parameter int       V_BP      = 12,
  parameter logic     HSYNC_POL = 1'b0,
  parameter logic     VSYNC_POL = 1'b0,
  parameter int       COLOR_W   = 8,
  parameter int       CHK_LOG2  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           mode,
  input  logic [3*COLOR_W-1:0] fill_rgb,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   green,
  output logic [COLOR_W-1:0]   blue,
  output logic                 dclk,
  output logic                 de,
  output logic                 hsync,
  output logic                 vsync,
  output logic [10:0]          x,
  output logic [9:0]           y,
  output logic                 frame_start
`ifdef LCD_FRAME_CNT_EN
  ,
  output logic [15:0]          frame_cnt
`endif
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int BAR_W = H_ACTIVE / 8;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [10:0] H_LAST  = 11'(H_TOT - 1);
  localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST  = 10'(V_TOT - 1);
  localparam logic [9:0]  V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_BEG  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] BAR_W_L = 11'(BAR_W);

  logic [DIV_W-1:0]   div_q, div_d;
  logic [10:0]        h_q, h_d;
  logic [9:0]         v_q, v_d;
  logic [1:0]         mode_q, mode_d;
  logic               dclk_q, dclk_d;
  logic               de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
  logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic [10:0]        x_q, x_d;
  logic [9:0]         y_q, y_d;

  logic               tick, origin, act;
  logic [1:0]         mode_eff;
  logic [2:0]         bar_i;
  logic [10:0]        bar_full;
  logic [COLOR_W-1:0] pr, pg, pb, grad_off;

`ifdef LCD_FRAME_CNT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        seen_q, seen_d;
`endif

  always_comb begin
    tick   = (div_q == DIV_LAST);
    div_d  = tick ? '0 : div_q + 1'b1;
    dclk_d = (div_d >= DIV_HALF);
    origin = (h_q == '0) && (v_q == '0);

    h_d = h_q;
    v_d = v_q;
    if (tick) begin
      h_d = (h_q == H_LAST) ? '0 : h_q + 11'd1;
      if (h_q == H_LAST) v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
    end

    // The pixel that opens a frame already uses the newly latched mode.
    mode_eff = origin ? mode : mode_q;
    mode_d   = (tick && origin) ? mode : mode_q;
    fs_d     = tick && origin;

`ifdef LCD_FRAME_CNT_EN
    // The first frame after reset is frame 0. Count from the second one on.
    seen_d   = seen_q | fs_d;
    cnt_d    = (fs_d && seen_q) ? cnt_q + 16'd1 : cnt_q;
    grad_off = COLOR_W'(cnt_d);
`else
    grad_off = '0;
`endif

    act      = (h_q < H_ACT) && (v_q < V_ACT);
    bar_full = h_q / BAR_W_L;
    bar_i    = bar_full[2:0];

    unique case (mode_eff)
      2'd0: begin
        pr = {COLOR_W{~bar_i[1]}};
        pg = {COLOR_W{~bar_i[2]}};
        pb = {COLOR_W{~bar_i[0]}};
      end
      2'd1: begin
        pr = COLOR_W'(h_q) + grad_off;
        pg = COLOR_W'(v_q);
        pb = '0;
      end
      2'd2: begin
        pr = {COLOR_W{h_q[CHK_LOG2] ^ v_q[CHK_LOG2]}};
        pg = pr;
        pb = pr;
      end
      default: {pr, pg, pb} = fill_rgb;
    endcase

    de_d = de_q; hs_d = hs_q; vs_d = vs_q;
    r_d  = r_q;  g_d  = g_q;  b_d  = b_q;
    x_d  = x_q;  y_d  = y_q;
    if (tick) begin
      de_d = act;
      hs_d = ((h_q >= HS_BEG) && (h_q < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
      vs_d = ((v_q >= VS_BEG) && (v_q < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
      r_d  = act ? pr : '0;
      g_d  = act ? pg : '0;
      b_d  = act ? pb : '0;
      x_d  = h_q;
      y_d  = v_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      h_q    <= '0;
      v_q    <= '0;
      mode_q <= '0;
      dclk_q <= 1'b0;
      de_q   <= 1'b0;
      hs_q   <= ~HSYNC_POL;
      vs_q   <= ~VSYNC_POL;
      r_q    <= '0;
      g_q    <= '0;
      b_q    <= '0;
      x_q    <= '0;
      y_q    <= '0;
      fs_q   <= 1'b0;
    end else begin
      div_q  <= div_d;
      h_q    <= h_d;
      v_q    <= v_d;
      mode_q <= mode_d;
      dclk_q <= dclk_d;
      de_q   <= de_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      r_q    <= r_d;
      g_q    <= g_d;
      b_q    <= b_d;
      x_q    <= x_d;
      y_q    <= y_d;
      fs_q   <= fs_d;
    end
  end

`ifdef LCD_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      seen_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      seen_q <= seen_d;
    end
  end
  assign frame_cnt = cnt_q;
`endif

  assign red         = r_q;
  assign green       = g_q;
  assign blue        = b_q;
  assign dclk        = dclk_q;
  assign de          = de_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Testbench for lcd_timing_gen on a tiny 14x7 raster (8/2/2/2, 4/1/1/1), CLK_DIV=2.
// Expected pixels are pushed into a queue. A monitor compares each expected pixel
// when the DUT presents that coordinate. Timing counts are checked inline.
module tb_lcd_timing_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic [23:0] fill_rgb;
  logic [7:0]  red, green, blue;
  logic        dclk, de, hsync, vsync, frame_start;
  logic [10:0] x;
  logic [9:0]  y;
`ifdef LCD_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  lcd_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .COLOR_W(8), .CHK_LOG2(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .fill_rgb(fill_rgb),
    .red(red), .green(green), .blue(blue), .dclk(dclk), .de(de),
    .hsync(hsync), .vsync(vsync), .x(x), .y(y), .frame_start(frame_start)
`ifdef LCD_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
    logic        de, hs, vs;
    logic [23:0] rgb;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic push(input int px, input int py, input logic pde, input logic phs,
                      input logic pvs, input logic [23:0] prgb);
    exp_t e;
    e.x = 11'(px); e.y = 10'(py); e.de = pde; e.hs = phs; e.vs = pvs; e.rgb = prgb;
    q.push_back(e);
  endtask

  // Monitor: a new pixel appears on the edge where dclk falls.
  initial begin
    logic prev_dclk;
    exp_t e;
    logic [26:0] act_v, exp_v;
    prev_dclk = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_dclk && !dclk && q.size() > 0 && x == q[0].x && y == q[0].y) begin
        e = q.pop_front();
        act_v = {de, hsync, vsync, red, green, blue};
        exp_v = {e.de, e.hs, e.vs, e.rgb};
        chk($sformatf("pix(%0d,%0d)", e.x, e.y), 64'(act_v), 64'(exp_v));
      end
      prev_dclk = dclk;
    end
  end

  task automatic wait_xy(input int tx, input int ty);
    int n = 0;
    while (!(x == 11'(tx) && y == 10'(ty) && !dclk) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk($sformatf("wait_xy(%0d,%0d)_timeout", tx, ty), 64'd1, 64'd0);
  endtask

  task automatic wait_fs(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 500);
    if (!frame_start) chk("frame_start_timeout", 64'd1, 64'd0);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("sb_drain", 64'(q.size()), 64'd0);
  endtask

  initial begin
    int n;
    int c_de, c_hs, c_vs, c_dclk, c_fs, c_tog;
    logic last_dclk;
    rst_n = 1'b0; mode = 2'd0; fill_rgb = 24'h0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 64'({de, hsync, vsync, dclk, red, green, blue, x, y, frame_start}),
        64'({1'b0, 1'b1, 1'b1, 1'b0, 24'h0, 11'd0, 10'd0, 1'b0}));

    // Frame 0, colour bars
    push(0, 0, 1, 1, 1, 24'hFFFFFF);
    push(1, 0, 1, 1, 1, 24'hFFFF00);
    push(5, 0, 1, 1, 1, 24'hFF0000);
    push(7, 0, 1, 1, 1, 24'h000000);
    push(9, 0, 0, 1, 1, 24'h000000);
    push(10, 0, 0, 0, 1, 24'h000000);
    push(2, 4, 0, 1, 1, 24'h000000);
    push(3, 5, 0, 1, 0, 24'h000000);
    rst_n = 1'b1;
    wait_fs(n);
    chk("first_fs_latency", 64'(n), 64'd2);

    c_de = 0; c_hs = 0; c_vs = 0; c_dclk = 0; c_fs = 0; c_tog = 0; last_dclk = dclk;
    for (int i = 0; i < 196; i++) begin
      c_de   += int'(de);
      c_hs   += int'(!hsync);
      c_vs   += int'(!vsync);
      c_dclk += int'(dclk);
      c_fs   += int'(frame_start);
      if (i > 0 && dclk != last_dclk) c_tog++;
      last_dclk = dclk;
      @(negedge clk);
    end
    chk("frame_de_clks", 64'(c_de), 64'd64);
    chk("frame_hsync_low_clks", 64'(c_hs), 64'd28);
    chk("frame_vsync_low_clks", 64'(c_vs), 64'd28);
    chk("frame_dclk_high_clks", 64'(c_dclk), 64'd98);
    chk("frame_dclk_toggles", 64'(c_tog), 64'd195);
    chk("frame_fs_count", 64'(c_fs), 64'd1);
    chk("fs_after_196", 64'(frame_start), 64'd1);
    drain();

    // Mode 0 -> 3 mid-frame: the rest of the frame stays bars.
    push(3, 2, 1, 1, 1, 24'h00FF00);
    push(0, 3, 1, 1, 1, 24'hFFFFFF);
    push(0, 0, 1, 1, 1, 24'h102030);
    push(9, 0, 0, 1, 1, 24'h000000);
    push(7, 3, 1, 1, 1, 24'h102030);
    wait_xy(0, 2);
    mode = 2'd3; fill_rgb = 24'h102030;
    drain();

    // Mode 3 -> 1 (gradient)
    wait_xy(0, 2);
    mode = 2'd1;
    push(5, 3, 1, 1, 1, 24'h102030);
    push(5, 2, 1, 1, 1, 24'h050200);
    drain();

    // Mode 1 -> 2 (checkerboard with 2-pixel cells)
    wait_xy(0, 3);
    mode = 2'd2;
    push(6, 3, 1, 1, 1, 24'h060300);
    push(1, 0, 1, 1, 1, 24'h000000);
    push(2, 0, 1, 1, 1, 24'hFFFFFF);
    push(0, 2, 1, 1, 1, 24'hFFFFFF);
    push(3, 3, 1, 1, 1, 24'h000000);
    drain();

    // Mid-line asynchronous reset
    wait_xy(5, 1);
    chk("pre_rst_de", 64'(de), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", 64'({de, hsync, vsync, dclk, red, green, blue, x, y, frame_start}),
        64'({1'b0, 1'b1, 1'b1, 1'b0, 24'h0, 11'd0, 10'd0, 1'b0}));
    mode = 2'd1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
`ifdef LCD_FRAME_CNT_EN
      push(3, 0, 1, 1, 1, {8'(3 + k), 8'h00, 8'h00});
`else
      push(3, 0, 1, 1, 1, 24'h030000);
`endif
    end
    rst_n = 1'b1;
    wait_fs(n);
    chk("rst_fs_latency", 64'(n), 64'd2);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        wait_fs(n);
        chk($sformatf("frame_period_%0d", k), 64'(n), 64'd196);
      end
`ifdef LCD_FRAME_CNT_EN
      chk($sformatf("frame_cnt_%0d", k), 64'(frame_cnt), 64'(k));
`endif
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
